// File: rtl/twilight_pkg.sv
// Shared day/night phase encoding and fade limits for the sky sequencer and background.
package twilight_pkg;

    typedef enum logic [1:0] {
        NIGHT = 2'd0,
        DAWN  = 2'd1,
        DAY   = 2'd2,
        DUSK  = 2'd3
    } phase_t;

    localparam logic [7:0] FADE_MIN = '0;
    localparam logic [7:0] FADE_MAX = '1;

endpackage

// File: rtl/fade_ramp.sv
// Saturating 8-bit fade step: adds (dir=1) or subtracts (dir=0) step and flags the limit.
module fade_ramp
    import twilight_pkg::*;
(
    input  logic [7:0] level,
    input  logic [7:0] step,
    input  logic       dir,
    output logic [7:0] next,
    output logic       at_limit
);

    logic [8:0] sum;
    logic [8:0] diff;

    assign sum  = {1'b0, level} + {1'b0, step};
    assign diff = {1'b0, level} - {1'b0, step};

    always_comb begin
        next     = level;
        at_limit = 1'b0;
        if (dir) begin
            next     = sum[8] ? FADE_MAX : sum[7:0];
            at_limit = (next == FADE_MAX);
        end else begin
            // diff[8] is the sign of the 9-bit signed result
            next     = diff[8] ? FADE_MIN : diff[7:0];
            at_limit = (next == FADE_MIN);
        end
    end

endmodule

// File: rtl/day_night_sequencer.sv
// Frame-rate day/night sequencer: holds night, ramps through dawn, holds day, ramps through dusk.
module day_night_sequencer
    import twilight_pkg::*;
#(
    parameter int unsigned NIGHT_FRAMES    = 240,
    parameter int unsigned DAY_FRAMES      = 240,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned RAMP_STEP       = 4
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    input  logic       frame,
    input  logic       pause,
    input  logic       skip,
    output logic [7:0] fade_level,
    output logic [1:0] phase,
    output logic       is_day,
    output logic       is_night,
    output logic       phase_change
);

    localparam int unsigned NF  = (NIGHT_FRAMES == 0)    ? 1 : NIGHT_FRAMES;
    localparam int unsigned DF  = (DAY_FRAMES == 0)      ? 1 : DAY_FRAMES;
    localparam int unsigned FPS = (FRAMES_PER_STEP == 0) ? 1 : FRAMES_PER_STEP;

    localparam logic [15:0] NIGHT_LAST = 16'(NF - 1);
    localparam logic [15:0] DAY_LAST   = 16'(DF - 1);
    localparam logic [15:0] STEP_LAST  = 16'(FPS - 1);
    localparam logic [7:0]  STEP8      = 8'(RAMP_STEP);

    phase_t      phase_q, phase_d;
    logic [7:0]  fade_q, fade_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] step_q, step_d;
    logic        skip_q, skip_d;
    logic        chg_q, chg_d;

    logic        accept;
    logic [7:0]  ramp_next;
    logic        ramp_limit;

    assign accept = frame & ~pause;

    fade_ramp u_fade_ramp (
        .level    (fade_q),
        .step     (STEP8),
        .dir      (phase_q == DAWN),
        .next     (ramp_next),
        .at_limit (ramp_limit)
    );

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= NIGHT;
            fade_q  <= FADE_MIN;
            hold_q  <= '0;
            step_q  <= '0;
            skip_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            fade_q  <= fade_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            skip_q  <= skip_d;
            chg_q   <= chg_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        fade_d  = fade_q;
        hold_d  = hold_q;
        step_d  = step_q;
        skip_d  = skip_q | skip;
        chg_d   = 1'b0;

        if (accept) begin
            // A skip raised on this very cycle counts, so test skip_d rather than skip_q
            if (skip_d) begin
                skip_d = 1'b0;
                hold_d = '0;
                step_d = '0;
                chg_d  = 1'b1;
                unique case (phase_q)
                    NIGHT: phase_d = DAWN;
                    DAWN: begin
                        phase_d = DAY;
                        fade_d  = FADE_MAX;
                    end
                    DAY:  phase_d = DUSK;
                    DUSK: begin
                        phase_d = NIGHT;
                        fade_d  = FADE_MIN;
                    end
                endcase
            end else begin
                unique case (phase_q)
                    NIGHT, DAY: begin
                        if (hold_q == ((phase_q == NIGHT) ? NIGHT_LAST : DAY_LAST)) begin
                            hold_d  = '0;
                            phase_d = (phase_q == NIGHT) ? DAWN : DUSK;
                            chg_d   = 1'b1;
                        end else begin
                            hold_d = hold_q + 16'd1;
                        end
                    end
                    DAWN, DUSK: begin
                        if (step_q == STEP_LAST) begin
                            step_d = '0;
                            fade_d = ramp_next;
                            if (ramp_limit) begin
                                phase_d = (phase_q == DAWN) ? DAY : NIGHT;
                                chg_d   = 1'b1;
                            end
                        end else begin
                            step_d = step_q + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign fade_level   = fade_q;
    assign phase        = phase_q;
    assign is_day       = (phase_q == DAY);
    assign is_night     = (phase_q == NIGHT);
    assign phase_change = chg_q;

endmodule

// File: tb/tb_day_night_sequencer.sv
// Scoreboard bench for day_night_sequencer: directed frames push expectations, monitors pop and compare.
module tb_day_night_sequencer;
    import twilight_pkg::*;

    typedef struct {
        string      name;
        logic [1:0] ph;
        logic [7:0] fade;
        logic       chg;
    } exp_t;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic       rst_n   = 1'b0;
    logic       frame_a = 1'b0;
    logic       pause_a = 1'b0;
    logic       skip_a  = 1'b0;
    logic       frame_b = 1'b0;
    logic       pause_b = 1'b0;
    logic       skip_b  = 1'b0;

    logic [7:0] fade_a, fade_b;
    logic [1:0] phase_a, phase_b;
    logic       day_a, night_a, chg_a;
    logic       day_b, night_b, chg_b;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned chg_cnt  = 0;

    day_night_sequencer #(
        .NIGHT_FRAMES    (3),
        .DAY_FRAMES      (2),
        .FRAMES_PER_STEP (1),
        .RAMP_STEP       (64)
    ) dut_a (
        .clk_pix      (clk_pix),
        .rst_n        (rst_n),
        .frame        (frame_a),
        .pause        (pause_a),
        .skip         (skip_a),
        .fade_level   (fade_a),
        .phase        (phase_a),
        .is_day       (day_a),
        .is_night     (night_a),
        .phase_change (chg_a)
    );

    day_night_sequencer #(
        .NIGHT_FRAMES    (2),
        .DAY_FRAMES      (2),
        .FRAMES_PER_STEP (3),
        .RAMP_STEP       (100)
    ) dut_b (
        .clk_pix      (clk_pix),
        .rst_n        (rst_n),
        .frame        (frame_b),
        .pause        (pause_b),
        .skip         (skip_b),
        .fade_level   (fade_b),
        .phase        (phase_b),
        .is_day       (day_b),
        .is_night     (night_b),
        .phase_change (chg_b)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endfunction

    always @(posedge clk_pix) if (chg_a) chg_cnt++;

    always begin : mon_a
        exp_t e;
        @(posedge clk_pix);
        if (frame_a) begin
            #1;
            if (qa.size() == 0) check("a_queue_underflow", 1, 0);
            else begin
                e = qa.pop_front();
                check({e.name, "_phase"}, phase_a, e.ph);
                check({e.name, "_fade"},  fade_a,  e.fade);
                check({e.name, "_chg"},   chg_a,   e.chg);
                check({e.name, "_isday"}, day_a,   e.ph == DAY);
                check({e.name, "_isngt"}, night_a, e.ph == NIGHT);
            end
        end
    end

    always begin : mon_b
        exp_t e;
        @(posedge clk_pix);
        if (frame_b) begin
            #1;
            if (qb.size() == 0) check("b_queue_underflow", 1, 0);
            else begin
                e = qb.pop_front();
                check({e.name, "_phase"}, phase_b, e.ph);
                check({e.name, "_fade"},  fade_b,  e.fade);
                check({e.name, "_chg"},   chg_b,   e.chg);
            end
        end
    end

    task automatic frm_a(input string n, input phase_t ph, input logic [7:0] fd,
                         input logic chg, input logic with_skip);
        qa.push_back('{n, ph, fd, chg});
        frame_a = 1'b1;
        skip_a  = with_skip;
        @(posedge clk_pix);
        #1;
        frame_a = 1'b0;
        skip_a  = 1'b0;
        repeat (2) @(posedge clk_pix);
        #1;
    endtask

    task automatic frm_b(input string n, input phase_t ph, input logic [7:0] fd, input logic chg);
        qb.push_back('{n, ph, fd, chg});
        frame_b = 1'b1;
        @(posedge clk_pix);
        #1;
        frame_b = 1'b0;
        repeat (2) @(posedge clk_pix);
        #1;
    endtask

    task automatic skip_pulse_a();
        skip_a = 1'b1;
        @(posedge clk_pix);
        #1;
        skip_a = 1'b0;
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        #2;
        check("rst_phase", phase_a, NIGHT);
        check("rst_fade",  fade_a,  0);
        check("rst_night", night_a, 1);
        check("rst_day",   day_a,   0);
        check("rst_chg",   chg_a,   0);
        @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        @(posedge clk_pix);
        #1;

        // Basic ramp and hold
        frm_a("t1_n0", NIGHT, 0,   0, 0);
        frm_a("t1_n1", NIGHT, 0,   0, 0);
        frm_a("t1_n2", DAWN,  0,   1, 0);
        frm_a("t1_u1", DAWN,  64,  0, 0);
        frm_a("t1_u2", DAWN,  128, 0, 0);
        frm_a("t1_u3", DAWN,  192, 0, 0);
        frm_a("t1_u4", DAY,   255, 1, 0);
        frm_a("t1_d0", DAY,   255, 0, 0);
        frm_a("t1_d1", DUSK,  255, 1, 0);
        frm_a("t1_k1", DUSK,  191, 0, 0);
        frm_a("t1_k2", DUSK,  127, 0, 0);
        frm_a("t1_k3", DUSK,  63,  0, 0);
        frm_a("t1_k4", NIGHT, 0,   1, 0);
        check("t1_chg_count", chg_cnt, 4);

        // Pause during dawn
        frm_a("t2_n0", NIGHT, 0,  0, 0);
        frm_a("t2_n1", NIGHT, 0,  0, 0);
        frm_a("t2_n2", DAWN,  0,  1, 0);
        frm_a("t2_u1", DAWN,  64, 0, 0);
        pause_a = 1'b1;
        for (int i = 0; i < 5; i++) frm_a("t2_paused", DAWN, 64, 0, 0);
        pause_a = 1'b0;
        frm_a("t2_resume", DAWN, 128, 0, 0);

        // Skip during pause at fade 128
        pause_a = 1'b1;
        skip_pulse_a();
        frm_a("t4_p0", DAWN, 128, 0, 0);
        frm_a("t4_p1", DAWN, 128, 0, 0);
        pause_a = 1'b0;
        frm_a("t4_jump", DAY, 255, 1, 0);

        // Skip mid-frame in day
        skip_pulse_a();
        frm_a("t3_dusk", DUSK, 255, 1, 0);
        frm_a("t3_k1",   DUSK, 191, 0, 0);

        // Asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_phase", phase_a, NIGHT);
        check("t5_fade",  fade_a,  0);
        check("t5_night", night_a, 1);
        check("t5_day",   day_a,   0);
        check("t5_chg",   chg_a,   0);
        @(posedge clk_pix);
        #1;
        rst_n = 1'b1;
        @(posedge clk_pix);
        #1;
        frm_a("t5_n0", NIGHT, 0, 0, 0);
        frm_a("t5_n1", NIGHT, 0, 0, 0);
        frm_a("t5_n2", DAWN,  0, 1, 0);

        // Skip coinciding with an accepted frame; day hold restarts from zero
        frm_a("t7_skip", DAY,  255, 1, 1);
        frm_a("t7_d0",   DAY,  255, 0, 0);
        frm_a("t7_d1",   DUSK, 255, 1, 0);

        // Step divider on the second instance
        frm_b("t6_n0", NIGHT, 0,   0);
        frm_b("t6_n1", DAWN,  0,   1);
        frm_b("t6_s1", DAWN,  0,   0);
        frm_b("t6_s2", DAWN,  0,   0);
        frm_b("t6_s3", DAWN,  100, 0);
        frm_b("t6_s4", DAWN,  100, 0);
        frm_b("t6_s5", DAWN,  100, 0);
        frm_b("t6_s6", DAWN,  200, 0);
        frm_b("t6_s7", DAWN,  200, 0);
        frm_b("t6_s8", DAWN,  200, 0);
        frm_b("t6_s9", DAY,   255, 1);

        for (int i = 0; i < 20 && (qa.size() + qb.size()) != 0; i++) @(posedge clk_pix);
        check("queue_drain", qa.size() + qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/day_night_sequencer.md
# day_night_sequencer

Frame-rate controller that sequences the sky's day/night cycle by generating the `fade_level` consumed by the twilight background generator. It holds night, ramps up through dawn, holds day and ramps down through dusk, advancing only on frame boundaries so the background never changes mid-frame. It sits beside the display timing generator, takes its frame-start pulse and drives `fade_level` directly into the background block.

## Interface
- `NIGHT_FRAMES`, default 240: frames spent in NIGHT hold; 0 is treated as 1.
- `DAY_FRAMES`, default 240: frames spent in DAY hold; 0 is treated as 1.
- `FRAMES_PER_STEP`, default 2: frames between ramp steps in DAWN/DUSK; 0 is treated as 1.
- `RAMP_STEP`, default 4: fade increment/decrement per step, range 1..255.
- `clk_pix`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame`  in  1  one-cycle pulse at frame start, from the timing generator.
- `pause`  in  1  level input; while high, `frame` pulses are ignored.
- `skip`  in  1  one-cycle request to end the current phase at the next accepted frame.
- `fade_level`  out  8  0 = full night, 255 = full day.
- `phase`  out  2  current phase, shared encoding.
- `is_day`  out  1  high iff phase is DAY.
- `is_night`  out  1  high iff phase is NIGHT.
- `phase_change`  out  1  one-cycle pulse after any phase transition.

## Operation
- An accepted frame is a cycle with `frame`=1 and `pause`=0. All state advances only on accepted frames, except `skip` capture.
- Phase encoding: NIGHT=0, DAWN=1, DAY=2, DUSK=3.
- The 16-bit `hold_cnt` runs in NIGHT and DAY. The 16-bit `step_cnt` runs in DAWN and DUSK.
- NIGHT: `fade_level`=0. On each accepted frame, `hold_cnt`++. When the frame with `hold_cnt`==NIGHT_FRAMES-1 is accepted, go to DAWN and clear `hold_cnt`.
- DAWN: on each accepted frame, `step_cnt`++. When `step_cnt`==FRAMES_PER_STEP-1:
  - clear `step_cnt`;
  - `fade_level` = min(`fade_level`+RAMP_STEP, 255), computed 9-bit then saturated;
  - if the result is 255, go to DAY in the same cycle.
- DAY: `fade_level`=255. Hold for DAY_FRAMES frames, same rule as NIGHT, then go to DUSK.
- DUSK: same step rule as DAWN, but `fade_level` = max(`fade_level`-RAMP_STEP, 0), computed signed 9-bit then clamped. When the result is 0, go to NIGHT.
- Skip handling:
  - `skip`=1 sets the sticky flag `skip_pend`.
  - On the next accepted frame with `skip_pend` set, the current phase ends immediately:
    - NIGHT→DAWN;
    - DAWN→DAY with `fade_level`=255;
    - DAY→DUSK;
    - DUSK→NIGHT with `fade_level`=0.
  - On that frame, counters clear and `skip_pend` clears. Normal counting is overridden.
- `skip` arriving in the same cycle as an accepted frame takes effect on that frame.
- A `skip` arriving during `pause` stays pending until the next accepted frame.
- `is_day` and `is_night` are decoded from the registered `phase`.

## Timing
- Reset values:
  - `phase`=NIGHT, `fade_level`=0, `is_night`=1, `is_day`=0, `phase_change`=0;
  - both counters 0, `skip_pend`=0.
- All outputs are registered. They update on the `clk_pix` edge that samples the accepted `frame`, so new values are visible one cycle after the `frame` pulse and stay stable for the whole frame.
- `phase_change` is high for exactly the one cycle in which the new `phase` is first visible.
- Deasserting `rst_n` mid-ramp returns to the reset values immediately, since reset is asynchronous. Reset release is synchronous to `clk_pix`, and the first accepted frame after release counts as NIGHT frame 0.
- `pause` does not alter any output. It only blocks advancement.
- Steady-state cycle length in frames:
  - NIGHT_FRAMES + DAY_FRAMES + 2·FRAMES_PER_STEP·ceil(255/RAMP_STEP).

## Structure
- Shared package `twilight_pkg` holds:
  - the phase localparams NIGHT/DAWN/DAY/DUSK;
  - the 2-bit phase type;
  - the fade constants FADE_MIN=0 and FADE_MAX=255.
- The twilight background block imports the same package if it ever needs to decode `phase`.
- One sub-module, `fade_ramp`, holds the saturating 8-bit up/down step:
  - inputs: `level`, `step`, `dir`;
  - outputs: `next` and `at_limit`.
- The FSM, counters and skip logic stay in the top level.

## Test plan
1. Reset ramp and hold: NIGHT_FRAMES=3, DAY_FRAMES=2, FRAMES_PER_STEP=1, RAMP_STEP=64, release reset and issue frames.
   - NIGHT for frames 0–2, then DAWN.
   - `fade_level` reads 64, 128, 192, 255 on successive frames.
   - DAY is entered on the frame where `fade_level` reaches 255.
   - DAY lasts 2 frames, then DUSK reads 191, 127, 63, 0, then NIGHT.
   - `phase_change` pulses exactly 4 times.
2. Pause: assert `pause` across 5 frame pulses during DAWN.
   - `fade_level` and `phase` stay unchanged.
   - Ramping resumes on the first frame after `pause` drops.
3. Skip in DAY: pulse `skip` mid-frame in DAY.
   - The next frame enters DUSK with `fade_level`=255 and `hold_cnt` cleared.
   - `phase_change` pulses once.
4. Skip during pause: pulse `skip` while `pause`=1 in DAWN at `fade_level`=128.
   - No change while paused.
   - The first accepted frame after `pause` drops jumps to DAY with `fade_level`=255.
5. Asynchronous reset: assert `rst_n`=0 mid-DUSK between clock edges.
   - Outputs are immediately NIGHT / 0 / `is_night`=1.
   - After release, NIGHT counts a full NIGHT_FRAMES.
6. Step divider: FRAMES_PER_STEP=3, RAMP_STEP=100.
   - DAWN levels change only every 3rd frame: 100, 200, 255.
   - Frames in between show no change.
